sram_byte_sequencer: RTL and testbench

- Sequences one 8-bit x 1024 OpenRAM macro (single read/write port) to serve the 32-bit picorv32 native memory interface.
- Each 32-bit access is split into four byte accesses. Read data is reassembled into a word. Writes honour mem_wstrb per byte lane.
- Sits between the picorv32 mem_* bus and the SRAM macro pins (csb0, web0, addr0, din0, dout0).

---
 rtl/sram_byte_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_sram_byte_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_byte_sequencer.sv
// rtl/sram_byte_sequencer.sv - picorv32 32-bit bus to 8-bit OpenRAM macro byte sequencer (optional SRAM_RANGE_CHK_EN)
module sram_byte_sequencer #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic [ADDR_W-1:0] sram_addr0,
  output logic [7:0]        sram_din0,
  input  logic [7:0]        sram_dout0,
`ifdef SRAM_RANGE_CHK_EN
  output logic              range_err,
`endif
  output logic              busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD      = 3'd1;
  localparam logic [2:0] S_RD_TAIL = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        tail_q, tail_d;
  logic              accept;
  logic              addr_oor;

  logic [ADDR_W-3:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              is_rd_q;
  logic              oor_q;

  logic [31:0]       rd_acc;
  logic [31:0]       asm_next;
  logic [7:0]        wr_byte;

  // read-issue tracking: stage 0 lines up with the cycle csb0 is low for a read
  logic              pv [0:RD_LAT];
  logic [1:0]        pl [0:RD_LAT];

  // word-alignment bits are never used; upper bits only matter with range checking
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADDR_W], mem_addr[1:0]};

`ifdef SRAM_RANGE_CHK_EN
  assign addr_oor = |mem_addr[31:ADDR_W];
`else
  assign addr_oor = 1'b0;
`endif

  // next-state, lane and tail counters
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    tail_d  = tail_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        lane_d = 2'd0;
        tail_d = 2'd0;
        if (mem_valid && !mem_ready) begin
          accept = 1'b1;
          if (addr_oor)
            state_d = S_DONE;
          else if (mem_wstrb == 4'b0000)
            state_d = S_RD;
          else
            state_d = S_WR;
        end
      end
      S_RD: begin
        if (lane_q == 2'd3) begin
          state_d = S_RD_TAIL;
          tail_d  = 2'd0;
        end else begin
          lane_d = lane_q + 2'd1;
        end
      end
      S_RD_TAIL: begin
        if (tail_q == 2'(RD_LAT - 1))
          state_d = S_DONE;
        else
          tail_d = tail_q + 2'd1;
      end
      S_WR: begin
        if (lane_q == 2'd3)
          state_d = S_DONE;
        else
          lane_d = lane_q + 2'd1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state register plus registered busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lane_q  <= 2'd0;
      tail_q  <= 2'd0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      tail_q  <= tail_d;
      busy    <= (state_d != S_IDLE);
    end
  end

  // request latch; contents frozen until the next acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      is_rd_q <= 1'b0;
      oor_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= mem_addr[ADDR_W-1:2];
      wdata_q <= mem_wdata;
      wstrb_q <= mem_wstrb;
      is_rd_q <= (mem_wstrb == 4'b0000);
      oor_q   <= addr_oor;
    end
  end

  // delay line marking when each issued read byte appears on dout0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        pv[i] <= 1'b0;
        pl[i] <= 2'd0;
      end
    end else begin
      pv[0] <= (state_q == S_RD);
      pl[0] <= lane_q;
      for (int i = 1; i <= RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pl[i] <= pl[i-1];
      end
    end
  end

  // merge the byte arriving this cycle into the partially assembled word
  always_comb begin
    asm_next = rd_acc;
    if (pv[RD_LAT]) begin
      case (pl[RD_LAT])
        2'd0:    asm_next[7:0]   = sram_dout0;
        2'd1:    asm_next[15:8]  = sram_dout0;
        2'd2:    asm_next[23:16] = sram_dout0;
        default: asm_next[31:24] = sram_dout0;
      endcase
    end
  end

  // read assembly register, cleared at the start of every transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_acc <= '0;
    else if (accept)
      rd_acc <= '0;
    else
      rd_acc <= asm_next;
  end

  // write byte for the current lane
  always_comb begin
    wr_byte = 8'h00;
    case (lane_q)
      2'd0:    wr_byte = wdata_q[7:0];
      2'd1:    wr_byte = wdata_q[15:8];
      2'd2:    wr_byte = wdata_q[23:16];
      default: wr_byte = wdata_q[31:24];
    endcase
  end

  // registered macro pins and bus response, decoded from the current state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ready  <= 1'b0;
      mem_rdata  <= '0;
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
`ifdef SRAM_RANGE_CHK_EN
      range_err  <= 1'b0;
`endif
    end else begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      sram_csb0 <= 1'b1;
      sram_web0 <= 1'b1;
`ifdef SRAM_RANGE_CHK_EN
      range_err <= 1'b0;
`endif
      case (state_q)
        S_RD: begin
          sram_csb0  <= 1'b0;
          sram_addr0 <= {addr_q, lane_q};
        end
        S_WR: begin
          sram_csb0  <= !wstrb_q[lane_q];
          sram_web0  <= 1'b0;
          sram_addr0 <= {addr_q, lane_q};
          sram_din0  <= wr_byte;
        end
        S_DONE: begin
          mem_ready <= 1'b1;
          mem_rdata <= (is_rd_q && !oor_q) ? asm_next : 32'h0;
`ifdef SRAM_RANGE_CHK_EN
          range_err <= oor_q;
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_byte_sequencer.sv
// tb/tb_sram_byte_sequencer.sv - directed self-checking bench for sram_byte_sequencer
module tb_sram_byte_sequencer;

  localparam int ADDR_W = 10;
  localparam int RD_LAT = 1;

  logic              clk;
  logic              rst;
  logic              mem_valid;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_rdata;
  logic              mem_ready;
  logic              sram_csb0;
  logic              sram_web0;
  logic [ADDR_W-1:0] sram_addr0;
  logic [7:0]        sram_din0;
  logic [7:0]        sram_dout0;
  logic              busy;
`ifdef SRAM_RANGE_CHK_EN
  logic              range_err;
`endif

  int errors = 0;
  int checks = 0;

  sram_byte_sequencer #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0),
`ifdef SRAM_RANGE_CHK_EN
    .range_err  (range_err),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural macro: writes and read launches on the edge, dout after RD_LAT edges
  logic [7:0]        sram_mem [0:(1<<ADDR_W)-1];
  logic [7:0]        rd_s0, rd_s1;
  logic [ADDR_W-1:0] wlog [$];
  int                csb_low_cnt = 0;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) sram_mem[i] = 8'h00;
    rd_s0 = 8'h00;
    rd_s1 = 8'h00;
  end

  always @(posedge clk) begin
    if (!sram_csb0) begin
      csb_low_cnt <= csb_low_cnt + 1;
      if (!sram_web0) begin
        sram_mem[sram_addr0] <= sram_din0;
        wlog.push_back(sram_addr0);
      end else begin
        rd_s0 <= sram_mem[sram_addr0];
      end
    end
    rd_s1 <= rd_s0;
  end

  assign sram_dout0 = (RD_LAT == 1) ? rd_s0 : rd_s1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xact(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      output int lat, output logic [31:0] rd, output logic re);
    @(negedge clk);
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    mem_valid = 1'b1;
    lat = -1;
    rd  = 32'hxxxx_xxxx;
    re  = 1'b0;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) chk("busy_after_accept", {31'd0, busy}, 32'd1);
      if (mem_ready) begin
        lat = k;
        rd  = mem_rdata;
`ifdef SRAM_RANGE_CHK_EN
        re  = range_err;
`endif
      end
    end
    // keep valid high across the cycle after ready: it must not start a new transaction
    @(posedge clk);
    #1;
    chk("no_reaccept_busy", {31'd0, busy}, 32'd0);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(negedge clk);
  endtask

  int          lat;
  logic [31:0] rd;
  logic        re;
  int          csb_before;
  logic        saw_ready;

  initial begin
    rst       = 1'b1;
    mem_valid = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    #12;
    chk("rst_csb0",  {31'd0, sram_csb0}, 32'd1);
    chk("rst_web0",  {31'd0, sram_web0}, 32'd1);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_addr0", {22'd0, sram_addr0}, 32'h0);
    chk("rst_din0",  {24'd0, sram_din0}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // full write then read at 0x10
    xact(32'h0000_0010, 32'hA1B2C3D4, 4'hF, lat, rd, re);
    chk("wr_full_lat", lat, 32'd5);
    chk("wr_full_rdata", rd, 32'h0);
    chk("mem_0x10", {24'd0, sram_mem[10'h10]}, 32'hD4);
    chk("mem_0x11", {24'd0, sram_mem[10'h11]}, 32'hC3);
    chk("mem_0x12", {24'd0, sram_mem[10'h12]}, 32'hB2);
    chk("mem_0x13", {24'd0, sram_mem[10'h13]}, 32'hA1);
    xact(32'h0000_0010, 32'h0, 4'h0, lat, rd, re);
    chk("rd_full_lat", lat, 32'(5 + RD_LAT));
    chk("rd_full_data", rd, 32'hA1B2C3D4);

    // partial write, lanes 0 and 2 only
    wlog.delete();
    xact(32'h0000_0010, 32'h11223344, 4'b0101, lat, rd, re);
    chk("wr_part_lat", lat, 32'd5);
    chk("wr_part_nacc", wlog.size(), 32'd2);
    if (wlog.size() == 2) begin
      chk("wr_part_addr_a", {22'd0, wlog[0]}, 32'h10);
      chk("wr_part_addr_b", {22'd0, wlog[1]}, 32'h12);
    end
    xact(32'h0000_0010, 32'h0, 4'h0, lat, rd, re);
    chk("rd_part_lat", lat, 32'(5 + RD_LAT));
    chk("rd_part_data", rd, 32'hA122C344);

`ifdef SRAM_RANGE_CHK_EN
    // out-of-range read: immediate completion with no macro traffic
    csb_before = csb_low_cnt;
    xact(32'h0000_0400, 32'h0, 4'h0, lat, rd, re);
    chk("oor_lat", lat, 32'd1);
    chk("oor_rdata", rd, 32'h0);
    chk("oor_range_err", {31'd0, re}, 32'd1);
    chk("oor_no_csb", csb_low_cnt - csb_before, 32'd0);
    xact(32'h0000_0010, 32'h0, 4'h0, lat, rd, re);
    chk("inrange_no_err", {31'd0, re}, 32'd0);
    chk("inrange_data", rd, 32'hA122C344);
`else
    // upper address bits dropped: 0x404 aliases 0x4
    xact(32'h0000_0404, 32'hDEADBEEF, 4'hF, lat, rd, re);
    chk("wrap_wr_lat", lat, 32'd5);
    chk("wrap_mem_0x4", {24'd0, sram_mem[10'h4]}, 32'hEF);
    chk("wrap_mem_0x7", {24'd0, sram_mem[10'h7]}, 32'hDE);
    xact(32'h0000_0004, 32'h0, 4'h0, lat, rd, re);
    chk("wrap_rd_lat", lat, 32'(5 + RD_LAT));
    chk("wrap_rd_data", rd, 32'hDEADBEEF);
`endif

    // reset during the lane-2 cycle of a read
    @(negedge clk);
    mem_addr  = 32'h0000_0010;
    mem_wstrb = 4'h0;
    mem_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("midrd_csb_active", {31'd0, sram_csb0}, 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("midrd_rst_csb0",  {31'd0, sram_csb0}, 32'd1);
    chk("midrd_rst_web0",  {31'd0, sram_web0}, 32'd1);
    chk("midrd_rst_busy",  {31'd0, busy}, 32'd0);
    chk("midrd_rst_ready", {31'd0, mem_ready}, 32'd0);
    chk("midrd_rst_addr0", {22'd0, sram_addr0}, 32'h0);
    mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    saw_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (mem_ready) saw_ready = 1'b1;
    end
    chk("midrd_no_ready", {31'd0, saw_ready}, 32'd0);
    xact(32'h0000_0010, 32'h0, 4'h0, lat, rd, re);
    chk("post_rst_lat", lat, 32'(5 + RD_LAT));
    chk("post_rst_data", rd, 32'hA122C344);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
